// File: rtl/vga_pixel_driver.sv
// VGA timing generator and pixel output pipeline: requests pixels, resamples
// them with fixed latency, and aligns syncs/blanking. Optional colour bars: VGA_TEST_PATTERN_EN.
module vga_pixel_driver #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_req,
    input  logic [23:0] idata,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vblank_pulse
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
    localparam int unsigned HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
    localparam int unsigned VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          vblank_d;
    logic          hs_raw_n, vs_raw_n;
    logic          req_d1_q, hs_d1_q, vs_d1_q;
    logic [23:0]   rgb_d;

    // Raster counters: vertical steps on horizontal wrap, both wrap together.
    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HW'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            if (v_cnt_q == VW'(V_TOTAL - 1)) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + VW'(1);
            end
        end
        vblank_d = (h_cnt_d == '0) && (v_cnt_d == VW'(V_ACTIVE));
    end

    assign pix_x    = 10'(h_cnt_q);
    assign pix_y    = 10'(v_cnt_q);
    assign pix_req  = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
    assign hs_raw_n = !((h_cnt_q >= HW'(HS_FIRST)) && (h_cnt_q <= HW'(HS_LAST)));
    assign vs_raw_n = !((v_cnt_q >= VW'(VS_FIRST)) && (v_cnt_q <= VW'(VS_LAST)));

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_d1_q;
    logic       unused_idata;

    assign unused_idata = ^idata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar_d1_q <= '0;
        end else begin
            bar_d1_q <= 3'(pix_x / 10'(BAR_W));
        end
    end

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        rgb_d = '0;
        if (req_d1_q) begin
            case (bar_d1_q)
                3'd0:    rgb_d = 24'hFFFFFF;
                3'd1:    rgb_d = 24'hFFFF00;
                3'd2:    rgb_d = 24'h00FFFF;
                3'd3:    rgb_d = 24'h00FF00;
                3'd4:    rgb_d = 24'hFF00FF;
                3'd5:    rgb_d = 24'hFF0000;
                3'd6:    rgb_d = 24'h0000FF;
                default: rgb_d = 24'h000000;
            endcase
        end
    end
`else
    always_comb begin
        rgb_d = '0;
        if (req_d1_q) begin
            rgb_d = idata;
        end
    end
`endif

    // Counters, the two-stage control delay and the colour register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            vblank_pulse <= 1'b0;
            req_d1_q     <= 1'b0;
            hs_d1_q      <= 1'b1;
            vs_d1_q      <= 1'b1;
            vga_blank_n  <= 1'b0;
            vga_hs       <= 1'b1;
            vga_vs       <= 1'b1;
            vga_r        <= '0;
            vga_g        <= '0;
            vga_b        <= '0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            vblank_pulse <= vblank_d;
            req_d1_q     <= pix_req;
            hs_d1_q      <= hs_raw_n;
            vs_d1_q      <= vs_raw_n;
            vga_blank_n  <= req_d1_q;
            vga_hs       <= hs_d1_q;
            vga_vs       <= vs_d1_q;
            vga_r        <= rgb_d[23:16];
            vga_g        <= rgb_d[15:8];
            vga_b        <= rgb_d[7:0];
        end
    end

endmodule
